// File: rtl/reg_file_hs.sv
// rtl/reg_file_hs.sv - multi-port register file, per-port four-phase req/ack handshake
// Optional macro REG_FILE_BYPASS_EN forwards same-edge write data to committing reads.
module reg_file_hs #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int NUM_RD  = 4,
    parameter int NUM_WR  = 3,
    parameter int ACK_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_ack,
    input  logic [NUM_WR-1:0]        wr_req,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [NUM_WR-1:0]        wr_ack,
    input  logic                     pc_wr,
    input  logic [DATA_W-1:0]        pc_wdata,
    output logic [DATA_W-1:0]        pc,
    input  logic                     cpsr_wr,
    input  logic [DATA_W-1:0]        cpsr_wdata,
    output logic [DATA_W-1:0]        cpsr
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] cpsr_q;
    logic [NUM_WR-1:0] wr_commit;
    logic [NUM_RD-1:0] rd_commit;

    genvar g;

    for (g = 0; g < NUM_WR; g++) begin : g_wr
        state_e           st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             commit;

        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            commit = 1'b0;
            case (st_q)
                S_IDLE: begin
                    if (wr_req[g]) begin
                        st_d  = S_WAIT;
                        cnt_d = CNT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (!wr_req[g]) begin
                        st_d = S_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        commit = 1'b1;
                        st_d   = S_ACK;
                    end
                end
                S_ACK: begin
                    if (!wr_req[g]) st_d = S_IDLE;
                end
                default: st_d = S_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q  <= S_IDLE;
                cnt_q <= '0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
            end
        end

        assign wr_commit[g] = commit;
        assign wr_ack[g]    = (st_q == S_ACK);
    end

    // Lowest port index is applied last so it wins; any port write overrides pc_wr.
    always_comb begin
        regs_d = regs_q;
        if (pc_wr) regs_d[DEPTH-1] = pc_wdata;
        for (int w = NUM_WR - 1; w >= 0; w--) begin
            if (wr_commit[w]) begin
                regs_d[wr_addr[w*ADDR_W +: ADDR_W]] = wr_data[w*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
        end
    end

    for (g = 0; g < NUM_RD; g++) begin : g_rd
        state_e            st_q, st_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              commit;
        logic [DATA_W-1:0] rd_src;
        logic [DATA_W-1:0] rd_q;

        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            commit = 1'b0;
            case (st_q)
                S_IDLE: begin
                    if (rd_req[g]) begin
                        st_d  = S_WAIT;
                        cnt_d = CNT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (!rd_req[g]) begin
                        st_d = S_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        commit = 1'b1;
                        st_d   = S_ACK;
                    end
                end
                S_ACK: begin
                    if (!rd_req[g]) st_d = S_IDLE;
                end
                default: st_d = S_IDLE;
            endcase
        end

`ifdef REG_FILE_BYPASS_EN
        assign rd_src = regs_d[rd_addr[g*ADDR_W +: ADDR_W]];
`else
        assign rd_src = regs_q[rd_addr[g*ADDR_W +: ADDR_W]];
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q  <= S_IDLE;
                cnt_q <= '0;
                rd_q  <= '0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                if (commit) rd_q <= rd_src;
            end
        end

        assign rd_commit[g]                = commit;
        assign rd_ack[g]                   = (st_q == S_ACK);
        assign rd_data[g*DATA_W +: DATA_W] = rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpsr_q <= '0;
        end else if (cpsr_wr) begin
            cpsr_q <= cpsr_wdata;
        end
    end

    assign pc   = regs_q[DEPTH-1];
    assign cpsr = cpsr_q;

endmodule

// File: doc/reg_file_hs.md
# reg_file_hs

Parametrised multi-port register file with an independent four-phase req/ack handshake on every read and write port, replacing the single shared req/ack pair of the previous register file. It sits between decode/issue and the execute units. It holds the general registers, a program-counter alias and a status register. It serialises same-address write conflicts by fixed priority and optionally forwards same-cycle write data to reads.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 4, number of read ports
- NUM_WR, 3, number of write ports
- ACK_LAT, 2, clocks from request acceptance to ack; legal range 1..15

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_req  in  NUM_RD  per-port read request, level, four-phase
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i uses slice [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, one slice per port
- rd_ack  out  NUM_RD  per-port read acknowledge
- wr_req  in  NUM_WR  per-port write request, level, four-phase
- wr_addr  in  NUM_WR*ADDR_W  write addresses, one slice per port
- wr_data  in  NUM_WR*DATA_W  write data, one slice per port
- wr_ack  out  NUM_WR  per-port write acknowledge
- pc_wr  in  1  PC update strobe, one cycle
- pc_wdata  in  DATA_W  PC update value
- pc  out  DATA_W  always equals entry DEPTH-1
- cpsr_wr  in  1  status update strobe, one cycle
- cpsr_wdata  in  DATA_W  status update value
- cpsr  out  DATA_W  status register

## Operation
- Each port has its own FSM with three states:
  - IDLE: when req=1 at an edge, go to WAIT and load cnt=ACK_LAT-1.
  - WAIT: if req=0 at an edge, abort to IDLE with no commit and no ack. Otherwise, if cnt>0, decrement cnt. If cnt==0, commit, set ack<=1 and go to ACK.
  - ACK: hold ack=1 while req=1. When req=0 at an edge, set ack<=0 and go to IDLE.
- Commit rules:
  - Write commit: entry[wr_addr] <= wr_data, using the addr/data sampled at the commit edge.
  - Read commit: rd_data slice <= entry[rd_addr]. rd_data then holds that value until the port's next read commit.
- Requester contract: addr and data stay stable from req rise until ack rise.
- Write priority: if several write ports commit to the same address on the same edge, the lowest port index wins. The losing ports still ack.
- pc_wr writes entry DEPTH-1. A port write committing to DEPTH-1 on the same edge overrides pc_wr.
- cpsr_wr loads cpsr on the edge it is sampled high.
- Read-during-write: a read and a write to the same address committing on the same edge returns the old value. REG_FILE_BYPASS_EN changes this (see Configuration).
- Reset (rst_n=0, at any time, including mid-transaction):
  - All entries, pc, cpsr and rd_data are 0.
  - All acks are 0 and all FSMs are IDLE.
  - In-flight writes are dropped.
  - Requests still high after reset release are accepted as new transactions.

## Timing
- Request sampled at edge E0 → ack visible after edge E0+ACK_LAT. A write is readable by a read committing at or after that edge.
- Ack falls on the first edge that samples req=0. The next request can be accepted on the following edge.
- Minimum cycle per port per transaction: ACK_LAT+2 clocks.
- Ports are fully independent; all NUM_RD+NUM_WR ports can be in flight simultaneously.
- pc and cpsr outputs are registered and update on the edge after the strobe/commit.
- No combinational path from any input to any output.

## Configuration
- REG_FILE_BYPASS_EN defined: a read committing on the same edge as a write to the same address returns the new data. When several writes hit that address, the read gets the winning (lowest-index) write's data. pc_wr to DEPTH-1 is forwarded the same way.
- REG_FILE_BYPASS_EN undefined: the read returns the pre-write value. This mode has no forwarding muxes.

## Test plan
- Reset then read: pulse rst_n low mid-write. Read addr 5 on port 0 → rd_data0=0, and wr_ack stays 0 for the aborted write.
- Basic write/read, ACK_LAT=2: write 0xDEADBEEF to addr 3 with req at E0 → wr_ack high after E2. Read addr 3 → 0xDEADBEEF, ack after its E2.
- Write conflict: ports 0/1/2 write 0x11/0x22/0x33 to addr 7 on the same edge → all three ack; addr 7 reads 0x11.
- Abort: raise wr_req, drop it after 1 cycle (ACK_LAT=3) → no ack; addr unchanged; FSM back to IDLE.
- Same-edge read/write to addr 9 (old 0xA, new 0xB) → rd_data = 0xB with REG_FILE_BYPASS_EN, 0xA without.
- PC/CPSR: pc_wr with 0x100 alongside a port write of 0x200 to addr 15 on the same edge → pc=0x200. cpsr_wr with 0xF0000000 → cpsr=0xF0000000 the next cycle.
